// File: rtl/router_fifo_pkt.sv
// Per-channel router output FIFO: stores {hdr, data}, registered read port,
// tracks the remaining length of the packet being read, sticky error flags.
module router_fifo_pkt #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 16,
  parameter int LEN_LSB   = 2,
  parameter int LEN_W     = 6,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       soft_reset,
  input  logic                       write_enb,
  input  logic                       lfd_state,
  input  logic [DATA_W-1:0]          data_in,
  input  logic                       read_enb,
  output logic [DATA_W-1:0]          data_out,
  output logic                       empty,
  output logic                       full,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH):0]     fill_level,
  output logic [LEN_W:0]             pkt_remaining,
  output logic                       last_byte,
  output logic                       overflow,
  output logic                       underflow
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]    PTR_ONE = 1;
  localparam logic [AW:0]    DEPTH_L = DEPTH[AW:0];
  localparam logic [AW:0]    AF_L    = AF_THRESH[AW:0];
  localparam logic [AW:0]    AE_L    = AE_THRESH[AW:0];
  localparam logic [LEN_W:0] REM_ONE = 1;

  logic [DATA_W:0]   r_mem [DEPTH];
  logic [AW:0]       r_wr_ptr, r_rd_ptr;
  logic [DATA_W-1:0] r_data_out;
  logic [LEN_W:0]    r_rem;
  logic              r_last, r_ovf, r_unf;

  logic [AW:0]       w_fill;
  logic              w_empty, w_full, w_rd_ok, w_wr_ok, w_hdr;
  logic [DATA_W:0]   w_rd_ent;
  logic [LEN_W:0]    w_len;

  always_comb begin
    w_fill   = r_wr_ptr - r_rd_ptr;
    w_empty  = (w_fill == '0);
    w_full   = (w_fill == DEPTH_L);
    w_rd_ok  = read_enb & ~w_empty;
    // A full FIFO still accepts a write when a read frees a slot this cycle.
    w_wr_ok  = write_enb & (~w_full | w_rd_ok);
    w_rd_ent = r_mem[r_rd_ptr[AW-1:0]];
    w_hdr    = w_rd_ent[DATA_W];
    w_len    = {1'b0, w_rd_ent[LEN_LSB +: LEN_W]} + REM_ONE;
  end

  always_ff @(posedge clock) begin
    if (w_wr_ok & ~soft_reset)
      r_mem[r_wr_ptr[AW-1:0]] <= {lfd_state, data_in};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_data_out <= '0;
      r_rem      <= '0;
      r_last     <= 1'b0;
      r_ovf      <= 1'b0;
      r_unf      <= 1'b0;
    end else if (soft_reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_data_out <= '0;
      r_rem      <= '0;
      r_last     <= 1'b0;
      r_ovf      <= 1'b0;
      r_unf      <= 1'b0;
    end else begin
      if (w_wr_ok) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_rd_ok) begin
        r_rd_ptr   <= r_rd_ptr + PTR_ONE;
        r_data_out <= w_rd_ent[DATA_W-1:0];
        // A header reloads even mid-packet; orphan bytes leave the count at 0.
        if (w_hdr)              r_rem <= w_len;
        else if (r_rem != '0)   r_rem <= r_rem - REM_ONE;
      end
      r_last <= w_rd_ok & ~w_hdr & (r_rem == REM_ONE);
      if (write_enb & ~w_wr_ok) r_ovf <= 1'b1;
      if (read_enb & w_empty)   r_unf <= 1'b1;
    end
  end

  assign data_out      = r_data_out;
  assign empty         = w_empty;
  assign full          = w_full;
  assign almost_full   = (w_fill >= AF_L);
  assign almost_empty  = (w_fill <= AE_L);
  assign fill_level    = w_fill;
  assign pkt_remaining = r_rem;
  assign last_byte     = r_last;
  assign overflow      = r_ovf;
  assign underflow     = r_unf;
endmodule

// File: tb/tb_router_fifo_pkt.sv
// Bench for router_fifo_pkt: queue-based reference model compared every cycle,
// plus directed literal expectations at the interesting points.
module tb_router_fifo_pkt;
  localparam int DW = 8, DEPTH = 16;

  logic          clock = 1'b0, reset, soft_reset, write_enb, lfd_state, read_enb;
  logic [DW-1:0] data_in, data_out;
  logic          empty, full, almost_full, almost_empty, last_byte, overflow, underflow;
  logic [4:0]    fill_level;
  logic [6:0]    pkt_remaining;
  logic          clk_run = 1'b0, chk_en = 1'b0;
  int            total = 0, bad = 0;

  router_fifo_pkt dut (
    .clock(clock), .reset(reset), .soft_reset(soft_reset), .write_enb(write_enb),
    .lfd_state(lfd_state), .data_in(data_in), .read_enb(read_enb), .data_out(data_out),
    .empty(empty), .full(full), .almost_full(almost_full), .almost_empty(almost_empty),
    .fill_level(fill_level), .pkt_remaining(pkt_remaining), .last_byte(last_byte),
    .overflow(overflow), .underflow(underflow));

  always #5 if (clk_run) clock = ~clock;

  // Reference model: a queue of {hdr,data} plus the packet/flag rules.
  logic [DW:0]   q[$];
  logic [DW-1:0] m_dout;
  int            m_rem;
  logic          m_lb, m_ov, m_uf;

  always @(posedge clock or posedge reset) begin
    logic [DW:0] e;
    bit em, rok, wok;
    if (reset || soft_reset) begin
      q.delete(); m_dout = '0; m_rem = 0; m_lb = 0; m_ov = 0; m_uf = 0;
    end else begin
      em  = (q.size() == 0);
      rok = read_enb && !em;
      wok = write_enb && (q.size() < DEPTH || rok);
      if (write_enb && !wok) m_ov = 1;
      if (read_enb && em)    m_uf = 1;
      m_lb = 0;
      if (rok) begin
        e = q.pop_front();
        m_dout = e[DW-1:0];
        if (e[DW]) m_rem = int'(e[7:2]) + 1;
        else begin
          m_lb = (m_rem == 1);
          if (m_rem > 0) m_rem = m_rem - 1;
        end
      end
      if (wok) q.push_back({lfd_state, data_in});
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h @%0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clock) if (chk_en && !reset) begin
    chk("m.data_out",  32'(data_out),      32'(m_dout));
    chk("m.fill",      32'(fill_level),    32'(q.size()));
    chk("m.empty",     32'(empty),         32'(q.size() == 0));
    chk("m.full",      32'(full),          32'(q.size() == DEPTH));
    chk("m.afull",     32'(almost_full),   32'(q.size() >= DEPTH - 2));
    chk("m.aempty",    32'(almost_empty),  32'(q.size() <= 2));
    chk("m.rem",       32'(pkt_remaining), 32'(m_rem));
    chk("m.last",      32'(last_byte),     32'(m_lb));
    chk("m.ovf",       32'(overflow),      32'(m_ov));
    chk("m.unf",       32'(underflow),     32'(m_uf));
  end

  task automatic cyc(input bit we, input bit lfd, input logic [DW-1:0] d, input bit re, input bit sr);
    write_enb = we; lfd_state = lfd; data_in = d; read_enb = re; soft_reset = sr;
    @(posedge clock); #1;
    write_enb = 0; lfd_state = 0; data_in = '0; read_enb = 0; soft_reset = 0;
  endtask

  initial begin
    logic [DW-1:0] rt_dat [5];
    int            rt_rem [5];
    rt_dat = '{8'h0C, 8'h11, 8'h22, 8'h33, 8'h5A};
    rt_rem = '{4, 3, 2, 1, 0};
    reset = 1; soft_reset = 0; write_enb = 0; lfd_state = 0; data_in = '0; read_enb = 0;

    // Reset with no clock running
    #3;
    chk("rst.empty", 32'(empty), 32'd1);
    chk("rst.fill",  32'(fill_level), 32'd0);
    chk("rst.dout",  32'(data_out), 32'd0);
    chk("rst.ovf",   32'(overflow), 32'd0);
    chk("rst.aempty",32'(almost_empty), 32'd1);
    clk_run = 1;
    @(posedge clock); #1 reset = 0; chk_en = 1;
    repeat (2) cyc(0, 0, 0, 0, 0);
    chk("idle.empty", 32'(empty), 32'd1);
    chk("idle.dout",  32'(data_out), 32'd0);

    // Packet round trip
    cyc(1, 1, 8'h0C, 0, 0);
    for (int i = 1; i < 5; i++) cyc(1, 0, rt_dat[i], 0, 0);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 0, 1, 0);
      chk("rt.dout", 32'(data_out), 32'(rt_dat[i]));
      chk("rt.rem",  32'(pkt_remaining), 32'(rt_rem[i]));
      chk("rt.last", 32'(last_byte), 32'(i == 4));
    end

    // Fill to full with threshold edges
    for (int i = 0; i < DEPTH; i++) begin
      cyc(1, 0, 8'(8'h40 + i), 0, 0);
      if (i == 1)  chk("fill.ae2",  32'(almost_empty), 32'd1);
      if (i == 2)  chk("fill.ae3",  32'(almost_empty), 32'd0);
      if (i == 12) chk("fill.af13", 32'(almost_full), 32'd0);
      if (i == 13) chk("fill.af14", 32'(almost_full), 32'd1);
    end
    chk("fill.full", 32'(full), 32'd1);
    chk("fill.lvl",  32'(fill_level), 32'd16);
    cyc(1, 0, 8'hEE, 1, 0);
    chk("full.rw.lvl", 32'(fill_level), 32'd16);
    chk("full.rw.ovf", 32'(overflow), 32'd0);
    chk("full.rw.dout",32'(data_out), 32'h40);
    cyc(1, 0, 8'hEF, 0, 0);
    chk("ovf.set", 32'(overflow), 32'd1);
    chk("ovf.lvl", 32'(fill_level), 32'd16);
    for (int i = 0; i < DEPTH; i++) cyc(0, 0, 0, 1, 0);
    chk("drain.empty", 32'(empty), 32'd1);
    chk("drain.last",  32'(data_out), 32'hEE);
    for (int i = 0; i < 20; i++) begin
      cyc(1, 0, 8'(8'h80 + i), 0, 0);
      cyc(0, 0, 0, 1, 0);
      chk("wrap.dout", 32'(data_out), 32'(8'h80 + i));
    end

    // Read+write while empty
    cyc(1, 0, 8'h77, 1, 0);
    chk("emp.rw.lvl",  32'(fill_level), 32'd1);
    chk("emp.rw.unf",  32'(underflow), 32'd1);
    chk("emp.rw.dout", 32'(data_out), 32'h93);

    // soft_reset mid-packet
    cyc(0, 0, 0, 1, 0);
    cyc(1, 1, 8'h14, 0, 0);
    for (int i = 0; i < 10; i++) cyc(1, 0, 8'(8'hA0 + i), 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1, 0);
    chk("sr.pre.rem", 32'(pkt_remaining), 32'd2);
    chk("sr.pre.lvl", 32'(fill_level), 32'd6);
    cyc(1, 0, 8'hCC, 0, 1);
    chk("sr.lvl",  32'(fill_level), 32'd0);
    chk("sr.rem",  32'(pkt_remaining), 32'd0);
    chk("sr.dout", 32'(data_out), 32'd0);
    chk("sr.flags",32'({overflow, underflow, last_byte}), 32'd0);

    // Maximum packet length
    cyc(1, 1, 8'hFC, 0, 0);
    cyc(0, 0, 0, 1, 0);
    chk("max.rem", 32'(pkt_remaining), 32'd64);
    for (int i = 1; i <= 64; i++) begin
      cyc(1, 0, 8'(i), 0, 0);
      cyc(0, 0, 0, 1, 0);
      if (i >= 63) chk("max.last", 32'(last_byte), 32'(i == 64));
    end
    chk("max.rem0", 32'(pkt_remaining), 32'd0);

    // Async reset mid-packet, between clock edges
    cyc(1, 1, 8'h0C, 0, 0);
    cyc(1, 0, 8'h21, 0, 0);
    cyc(1, 0, 8'h22, 1, 0);
    #1 reset = 1;
    #1;
    chk("arst.lvl",  32'(fill_level), 32'd0);
    chk("arst.rem",  32'(pkt_remaining), 32'd0);
    chk("arst.dout", 32'(data_out), 32'd0);
    @(negedge clock); #1 reset = 0;
    repeat (2) cyc(0, 0, 0, 0, 0);
    chk("arst.hold", 32'(empty), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
